// File: rtl/float_if_pkg.sv
// Shared types and default sizes for the float core front end.
//   DEF_SIZE            operand/result width (IEEE-754 single)
//   DEF_TAG_W           destination-register tag width
//   DEF_MAX_OUTSTANDING default in-flight op bound
//   tag_t               destination tag at the default width
//   issue_state_t       operand issue FSM states
package float_if_pkg;

    localparam int DEF_SIZE            = 32;
    localparam int DEF_TAG_W           = 5;
    localparam int DEF_MAX_OUTSTANDING = 32;

    typedef logic [DEF_TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_A,
        WAIT_B
    } issue_state_t;

endpackage

// File: rtl/float_unit_driver_tag_fifo.sv
// tag_fifo: synchronous FIFO holding destination tags of ops issued to the
// core, in issue order.
//   aclk, aresetn      clock, async active-low reset (pointers only)
//   push, push_data    write a tag (caller never pushes when full)
//   pop                drop the head (caller never pops when empty)
//   empty              no tag pending
//   head               oldest tag
module tag_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 5
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit: equal pointers mean empty, equal low bits with
    // differing MSB would mean full.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [W-1:0]   mem [DEPTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/float_unit_driver.sv
// float_unit_driver: front end between the shader pipeline and a
// two-operand float core (sqrt/add/mul).
//   aclk, aresetn                 clock, async active-low reset
//   req_valid/ready, req_a/b/tag  tagged operand request from the pipeline
//   m_axis_a_*, m_axis_b_*        operand streams to the core (master)
//   s_axis_result_*               result stream from the core (slave)
//   rsp_valid/ready, rsp_data/tag in-order result plus its tag
//   outstanding                   ops reserved or in flight
//   err_orphan                    sticky: core result with no tag pending
module float_unit_driver
    import float_if_pkg::*;
#(
    parameter  int SIZE            = DEF_SIZE,
    parameter  int TAG_W           = DEF_TAG_W,
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SIZE-1:0]  req_a,
    input  logic [SIZE-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [SIZE-1:0]  m_axis_a_tdata,
    output logic             m_axis_a_tvalid,
    input  logic             m_axis_a_tready,
    output logic [SIZE-1:0]  m_axis_b_tdata,
    output logic             m_axis_b_tvalid,
    input  logic             m_axis_b_tready,
    input  logic [SIZE-1:0]  s_axis_result_tdata,
    input  logic             s_axis_result_tvalid,
    output logic             s_axis_result_tready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SIZE-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_orphan
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    issue_state_t     state, state_nxt;
    logic [SIZE-1:0]  a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             issue_done;
    logic             res_hs;
    logic             fifo_empty;
    logic [TAG_W-1:0] fifo_head;

    // Gated by aresetn so the pipeline sees no ready while reset is held.
    assign req_ready = aresetn && (state == IDLE) && (outstanding < MAX_CNT);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // tvalid is a pure function of state, never of tready.
    always_comb begin
        state_nxt       = state;
        issue_done      = 1'b0;
        m_axis_a_tvalid = 1'b0;
        m_axis_b_tvalid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                m_axis_a_tvalid = 1'b1;
                m_axis_b_tvalid = 1'b1;
                if (m_axis_a_tready && m_axis_b_tready) begin
                    state_nxt  = IDLE;
                    issue_done = 1'b1;
                end else if (m_axis_a_tready) begin
                    state_nxt = WAIT_B;
                end else if (m_axis_b_tready) begin
                    state_nxt = WAIT_A;
                end
            end
            WAIT_A: begin
                m_axis_a_tvalid = 1'b1;
                if (m_axis_a_tready) begin
                    state_nxt  = IDLE;
                    issue_done = 1'b1;
                end
            end
            WAIT_B: begin
                m_axis_b_tvalid = 1'b1;
                if (m_axis_b_tready) begin
                    state_nxt  = IDLE;
                    issue_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands only load in IDLE, so they stay put for the whole issue.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            tag_q <= req_tag;
        end
    end

    assign m_axis_a_tdata = a_q;
    assign m_axis_b_tdata = b_q;

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (TAG_W)
    ) u_tag_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (issue_done),
        .push_data (tag_q),
        .pop       (res_hs),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A result is only taken when its tag is known and the response
    // register is free or draining this cycle.
    assign s_axis_result_tready = !fifo_empty && (!rsp_valid || rsp_ready);
    assign res_hs               = s_axis_result_tvalid && s_axis_result_tready;

    // Credit is taken at accept, so the FIFO can never be pushed while full.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else begin
            case ({accept, res_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else if (res_hs) begin
            rsp_valid <= 1'b1;
            rsp_data  <= s_axis_result_tdata;
            rsp_tag   <= fifo_head;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                err_orphan <= 1'b0;
        else if (s_axis_result_tvalid && fifo_empty) err_orphan <= 1'b1;
    end

endmodule
